// File: rtl/seg_display_pkg.sv
// Shared types and constants for the two-digit seven-segment display path.
package seg_display_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX   = 4'd9;
  localparam int         SYNC_STAGES = 2;

  // 10 ms of stable level at a 25 MHz system clock.
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;

endpackage

// File: rtl/debounce_edge_detect.sv
// One pushbutton: two-flop synchroniser, hold-time debouncer and a
// registered single-cycle pulse on each accepted press.
module debounce_edge_detect
  import seg_display_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       count;
  logic                   synced;
  logic                   level;
  logic                   level_d;
  logic                   press;

  assign synced = sync[SYNC_STAGES-1];

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreeing sample throws the partial count away.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync    <= '0;
      count   <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], i_Switch};
      level_d <= level;
      press   <= level & ~level_d;
      if (synced == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= synced;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign o_Level = level;
  assign o_Press = press;

endmodule

// File: rtl/switch_bcd_counter.sv
// Three debounced pushbuttons driving a two-digit BCD up/down counter that
// wraps between 00 and MAX_COUNT.
module switch_bcd_counter
  import seg_display_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int MAX_COUNT      = 99
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_Inc,
  input  logic       i_Switch_Dec,
  input  logic       i_Switch_Clr,
  output bcd_digit_t o_Tens,
  output bcd_digit_t o_Ones,
  output logic       o_Wrap
);

  localparam bcd_digit_t MAX_TENS = bcd_digit_t'(MAX_COUNT / 10);
  localparam bcd_digit_t MAX_ONES = bcd_digit_t'(MAX_COUNT % 10);

  logic       inc_press;
  logic       dec_press;
  logic       clr_press;
  logic [2:0] levels_unused;

  bcd_digit_t tens;
  bcd_digit_t ones;
  logic       wrap;

  debounce_edge_detect #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_inc (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_Inc),
    .o_Level  (levels_unused[0]),
    .o_Press  (inc_press)
  );

  debounce_edge_detect #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_dec (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_Dec),
    .o_Level  (levels_unused[1]),
    .o_Press  (dec_press)
  );

  debounce_edge_detect #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_clr (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch_Clr),
    .o_Level  (levels_unused[2]),
    .o_Press  (clr_press)
  );

  // Clear beats everything; simultaneous inc and dec cancel out.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      tens <= '0;
      ones <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_press) begin
        tens <= '0;
        ones <= '0;
      end else if (inc_press && !dec_press) begin
        if (tens == MAX_TENS && ones == MAX_ONES) begin
          tens <= '0;
          ones <= '0;
          wrap <= 1'b1;
        end else if (ones == DIGIT_MAX) begin
          ones <= '0;
          tens <= tens + 4'd1;
        end else begin
          ones <= ones + 4'd1;
        end
      end else if (dec_press && !inc_press) begin
        if (tens == '0 && ones == '0) begin
          tens <= MAX_TENS;
          ones <= MAX_ONES;
          wrap <= 1'b1;
        end else if (ones == '0) begin
          ones <= DIGIT_MAX;
          tens <= tens - 4'd1;
        end else begin
          ones <= ones - 4'd1;
        end
      end
    end
  end

  assign o_Tens = tens;
  assign o_Ones = ones;
  assign o_Wrap = wrap;

endmodule
